// File: rtl/multi_debouncer.sv
// Multi-channel contact debouncer: per-channel synchroniser, consecutive-sample
// filter and registered rise/fall pulses, with a global enable that freezes filtering.
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 16,
    parameter int DEBOUNCE_TIME = 27000,
    parameter int SYNC_STAGES   = 2,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CHANNELS-1:0] noisy_signal,
    output logic [CHANNELS-1:0] clean_signal,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TIME - 1);

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CNT_W-1:0]       cnt_q  [CHANNELS];
    logic [CNT_W-1:0]       cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]    s;
    logic [CHANNELS-1:0]    clean_d;
    logic [CHANNELS-1:0]    rise_d;
    logic [CHANNELS-1:0]    fall_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // cnt holds the length of the current disagreement run minus nothing:
    // the DEBOUNCE_TIME-th consecutive enabled mismatch is the accepting sample.
    always_comb begin
        clean_d = clean_signal;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (enable) begin
                if (s[i] == clean_signal[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = s[i];
                    fall_d[i]  = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {SYNC_STAGES{RESET_LEVEL}};
                cnt_q[i]  <= '0;
            end
            clean_signal <= {CHANNELS{RESET_LEVEL}};
            rise_pulse   <= '0;
            fall_pulse   <= '0;
            any_change   <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], noisy_signal[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            clean_signal <= clean_d;
            rise_pulse   <= rise_d;
            fall_pulse   <= fall_d;
            any_change   <= |(rise_d | fall_d);
        end
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios plus random bouncing, checked
// every cycle against a sample-history reference model through an expected queue.
module tb_multi_debouncer;

    localparam int CH = 4;
    localparam int CW = 16;
    localparam int DT = 8;
    localparam int SS = 2;
    localparam bit RL = 1'b0;
    localparam int EW = 3 * CH + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [CH-1:0] noisy_signal = '0;
    logic [CH-1:0] clean_signal;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic          any_change;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    multi_debouncer #(
        .CHANNELS(CH), .CNT_W(CW), .DEBOUNCE_TIME(DT),
        .SYNC_STAGES(SS), .RESET_LEVEL(RL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .noisy_signal(noisy_signal),
        .clean_signal(clean_signal), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .any_change(any_change)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Synchroniser = pure delay of SS samples; a level is accepted once the
    // last DT enabled samples all disagree with the current clean level.
    logic [CH-1:0] m_pipe[$];
    logic [CH-1:0] m_clean;
    bit            m_hist[CH][$];

    always @(posedge clk) begin : model
        logic [CH-1:0] ms, r, f;
        bit all_diff;
        r = '0;
        f = '0;
        if (rst) begin
            m_pipe.delete();
            for (int k = 0; k < SS; k++) m_pipe.push_back({CH{RL}});
            m_clean = {CH{RL}};
            for (int i = 0; i < CH; i++) m_hist[i].delete();
        end else begin
            ms = m_pipe.pop_front();
            m_pipe.push_back(noisy_signal);
            if (enable) begin
                for (int i = 0; i < CH; i++) begin
                    m_hist[i].push_back(ms[i]);
                    if (m_hist[i].size() > DT) void'(m_hist[i].pop_front());
                    all_diff = (m_hist[i].size() == DT);
                    for (int k = 0; k < m_hist[i].size(); k++)
                        if (m_hist[i][k] == m_clean[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_clean[i] = ms[i];
                        r[i] = ms[i];
                        f[i] = ~ms[i];
                    end
                end
            end
        end
        exp_q.push_back({m_clean, r, f, |(r | f)});
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {clean_signal, rise_pulse, fall_pulse, any_change};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got clean=%h rise=%h fall=%h any=%b exp clean=%h rise=%h fall=%h any=%b",
                         $time, got[EW-1 -: CH], got[2*CH -: CH], got[CH -: CH], got[0],
                         e[EW-1 -: CH], e[2*CH -: CH], e[CH -: CH], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Cycles until clean_signal[ch]==val, bounded; compared with the expected latency.
    task automatic wait_level(input int ch, input logic val, input int exp_lat, input string name);
        int lat;
        lat = 0;
        while (clean_signal[ch] !== val && lat < 40) begin
            cyc(1);
            lat++;
        end
        check(name, lat, exp_lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n_bounce, n_any, lat;
        bit saw;
        int flip_div;

        // Reset with all inputs high.
        rst = 1'b1;
        noisy_signal = 4'hF;
        cyc(1);
        repeat (3) begin
            cyc(1);
            check("rst_clean", clean_signal, 0);
            check("rst_pulses", {rise_pulse, fall_pulse, any_change}, 0);
        end
        rst = 1'b0;
        lat = 0;
        n_bounce = 0;
        while (clean_signal !== 4'hF && lat < 40) begin
            cyc(1);
            lat++;
            if (rise_pulse == 4'hF) n_bounce++;
        end
        check("rst_latency", lat, SS + DT);
        check("rst_rise_once", n_bounce, 1);

        // Clean step on channel 0 (after bringing everything low).
        noisy_signal = 4'h0;
        cyc(SS + DT + 2);
        noisy_signal[0] = 1'b1;
        wait_level(0, 1'b1, SS + DT, "step_latency");
        check("step_rise", rise_pulse[0], 1);
        check("step_any", any_change, 1);
        cyc(1);
        check("step_rise_1cyc", rise_pulse[0], 0);

        // Bounce rejection on channel 1.
        n_bounce = 0;
        repeat (3) begin
            noisy_signal[1] = 1'b1;
            repeat (5) begin
                cyc(1);
                if (rise_pulse[1] || fall_pulse[1]) n_bounce++;
            end
            noisy_signal[1] = 1'b0;
            cyc(1);
            if (rise_pulse[1] || fall_pulse[1]) n_bounce++;
        end
        check("bounce_no_pulse", n_bounce, 0);
        noisy_signal[1] = 1'b1;
        wait_level(1, 1'b1, SS + DT, "bounce_latency");

        // Enable gating on channel 2.
        noisy_signal[2] = 1'b1;
        cyc(SS + 4);
        enable = 1'b0;
        n_bounce = 0;
        repeat (20) begin
            cyc(1);
            if (rise_pulse != 0 || fall_pulse != 0) n_bounce++;
        end
        check("gate_held", clean_signal[2], 0);
        check("gate_no_pulse", n_bounce, 0);
        enable = 1'b1;
        cyc(3);
        check("gate_not_yet", clean_signal[2], 0);
        cyc(1);
        check("gate_rise", clean_signal[2], 1);

        // Simultaneous events: ch0,ch3 fall while ch1 rises.
        noisy_signal = 4'b1001;
        cyc(SS + DT + 3);
        noisy_signal = 4'b0010;
        saw = 1'b0;
        n_any = 0;
        repeat (SS + DT + 4) begin
            cyc(1);
            if (fall_pulse == 4'b1001 && rise_pulse == 4'b0010) saw = 1'b1;
            if (any_change) n_any++;
        end
        check("simul_pulses", saw, 1);
        check("simul_any_once", n_any, 1);

        // Reset mid-count on channel 0.
        noisy_signal = 4'h0;
        cyc(SS + DT + 3);
        noisy_signal[0] = 1'b1;
        cyc(SS + 6);
        rst = 1'b1;
        cyc(1);
        check("midrst_clean", clean_signal, 0);
        check("midrst_no_pulse", {rise_pulse, fall_pulse, any_change}, 0);
        rst = 1'b0;
        wait_level(0, 1'b1, SS + DT, "midrst_latency");

        // Randomised bouncing, enable gating and occasional reset.
        for (int blk = 0; blk < 15; blk++) begin
            flip_div = (blk % 2 == 0) ? 3 : 14;
            repeat (200) begin
                for (int i = 0; i < CH; i++)
                    if ($urandom_range(flip_div - 1, 0) == 0) noisy_signal[i] = ~noisy_signal[i];
                enable = ($urandom_range(9, 0) != 0);
                rst = ($urandom_range(249, 0) == 0);
                cyc(1);
            end
        end
        rst = 1'b0;
        enable = 1'b1;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
